unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory address every cycle.
- Captures the byte the memory returns into an IF/ID register, tagged with its PC and a valid bit, for the decoder.
- Handles stall, redirect (branch/jump), squash of the wrong-path fetch, and halt.

Parameters:
LARGURA_END, 8, PC/address width
LARGURA_INSTR, 8, instruction width
PC_INICIAL, 8'h00, PC value on reset
OPCODE_HALT, 8'hFF, instruction byte that halts fetch
PROF_PILHA, 4, return-stack depth (only with PILHA_RETORNO_EN)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
endereco  output  LARGURA_END  address to instruction memory (= pc register)
instrucao_entrada  input  LARGURA_INSTR  memory read data; memory samples endereco on negedge, so data is stable by the next posedge
stall  input  1  hold the whole stage
redir_valido  input  1  redirect request from a later stage
redir_alvo  input  LARGURA_END  redirect target
chamada_valida  input  1  call request (target = redir_alvo)
retorno_valido  input  1  return request
instrucao_saida  output  LARGURA_INSTR  IF/ID instruction
pc_instrucao  output  LARGURA_END  PC of instrucao_saida
instrucao_valida  output  1  IF/ID contents valid
parado  output  1  fetch halted
erro_pilha  output  1  sticky return-stack over/underflow flag

Behaviour:
- Reset (reset=0, async):
  - pc=PC_INICIAL; instrucao_saida=0; pc_instrucao=0.
  - instrucao_valida=0; parado=0; erro_pilha=0.
  - Stack pointer = 0. State BUSCA.
- endereco is always combinationally equal to the pc register.
- Latency: the instruction at address A (pc=A during cycle k) appears on the IF/ID outputs after posedge k+1. First valid output is mem[PC_INICIAL] one posedge after reset release.
- States: BUSCA, PARADO.
- Per-posedge priority in BUSCA:
  1. Redirect (redir_valido, or call/return per Optional Feature):
     - pc <= target.
     - IF/ID loads instrucao_valida=0 (squash the wrong-path byte now arriving).
     - Other IF/ID fields are don't-care; hold them.
     - Redirect overrides stall.
  2. stall=1: pc and all IF/ID outputs hold.
  3. Otherwise:
     - IF/ID <= {instrucao_entrada, pc, valid=1}.
     - pc <= pc+1, modulo 2^LARGURA_END (8'hFF wraps to 8'h00).
     - If instrucao_entrada == OPCODE_HALT: pc holds instead of incrementing; state -> PARADO; parado=1 from the same edge. The halt byte itself is delivered once with valid=1.
- PARADO:
  - pc holds; next posedge clears instrucao_valida; outputs then hold.
  - stall, redirect, call and return are ignored. Exit only by reset.
- Simultaneous events:
  - Redirect plus a halt byte arriving: redirect wins; halt is squashed; stay in BUSCA.
  - Stall plus a halt byte: nothing captured; halt detected when the stall releases.
- Reset mid-operation (including in PARADO or under stall) returns to the reset state immediately and asynchronously.

Optional Feature:
- Macro: PILHA_RETORNO_EN.
- Defined:
  - PROF_PILHA-entry return stack.
  - chamada_valida pushes pc_instrucao+1 (return address of the call in IF/ID) and redirects to redir_alvo.
  - retorno_valido pops and redirects to the popped value.
  - Priority: redir_valido > chamada_valida > retorno_valido.
  - Push when full: overwrite the oldest entry (circular) and set erro_pilha.
  - Pop when empty: redirect to PC_INICIAL and set erro_pilha.
  - erro_pilha clears only on reset.
  - Call and return obey the same squash and PARADO rules as redirect.
- Not defined:
  - chamada_valida acts as a plain redirect to redir_alvo.
  - retorno_valido is ignored.
  - erro_pilha is tied to 0; no stack storage.

Test Plan:
- Reset, memory 00:11,01:22,02:33, release, no stall -> posedges 1,2,3 output (11,pc0),(22,pc1),(33,pc2); valid=1; endereco 1,2,3.
- stall=1 for 2 cycles at pc=5 -> endereco stays 5 and outputs frozen; fetch resumes with mem[5] next.
- redir_valido with redir_alvo=8'h40 while pc=7 -> next edge valid=0, endereco=8'h40; following edge outputs (mem[40],pc 40).
- pc reaches 8'hFF -> fetches mem[FF] then endereco=8'h00; mem[03]=FF -> FF delivered valid once, parado=1, endereco holds 03+0, valid=0 next, redirect ignored.
- Assert reset low mid-stall and in PARADO -> outputs zero immediately, endereco=PC_INICIAL without a clock edge.
- With PILHA_RETORNO_EN, PROF_PILHA=4: call at pc_instrucao=10 to 80 then return -> fetch resumes at 11; 5 nested calls -> erro_pilha=1; return on empty -> endereco=PC_INICIAL.

Source files
------------

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// unidade_busca : instruction-fetch stage (PC, IF/ID register, stall,
//                 redirect/squash, halt). Optional return stack: PILHA_RETORNO_EN
// Revision 1.0
// ============================================================================
module unidade_busca #(
  parameter int                       LARGURA_END   = 8,
  parameter int                       LARGURA_INSTR = 8,
  parameter logic [LARGURA_END-1:0]   PC_INICIAL    = 8'h00,
  parameter logic [LARGURA_INSTR-1:0] OPCODE_HALT   = 8'hFF,
  parameter int                       PROF_PILHA    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [LARGURA_END-1:0]   endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao_entrada,
  input  logic                     stall,
  input  logic                     redir_valido,
  input  logic [LARGURA_END-1:0]   redir_alvo,
  input  logic                     chamada_valida,
  input  logic                     retorno_valido,
  output logic [LARGURA_INSTR-1:0] instrucao_saida,
  output logic [LARGURA_END-1:0]   pc_instrucao,
  output logic                     instrucao_valida,
  output logic                     parado,
  output logic                     erro_pilha
);

  typedef enum logic [0:0] {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

  estado_t                  r_estado;
  logic [LARGURA_END-1:0]   r_pc;
  logic [LARGURA_INSTR-1:0] r_instr;
  logic [LARGURA_END-1:0]   r_pc_instr;
  logic                     r_valida;
  logic                     r_parado;

  logic                     w_redir;
  logic [LARGURA_END-1:0]   w_alvo;

`ifdef PILHA_RETORNO_EN
  localparam int c_LARGURA_IDX = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;
  localparam int c_LARGURA_QTD = $clog2(PROF_PILHA + 1);

  logic [LARGURA_END-1:0]   r_pilha [PROF_PILHA];
  logic [c_LARGURA_IDX-1:0] r_topo;
  logic [c_LARGURA_QTD-1:0] r_qtd;
  logic                     r_erro;

  logic                     w_push;
  logic                     w_pop;
  logic [c_LARGURA_IDX-1:0] w_topo_prox;
  logic [c_LARGURA_IDX-1:0] w_topo_ant;

  // r_topo is the next write slot; the stack wraps so a push when full drops the oldest
  always_comb begin
    w_topo_prox = (r_topo == c_LARGURA_IDX'(PROF_PILHA - 1)) ? '0 : r_topo + 1'b1;
    w_topo_ant  = (r_topo == '0) ? c_LARGURA_IDX'(PROF_PILHA - 1) : r_topo - 1'b1;
    w_push      = !redir_valido && chamada_valida;
    w_pop       = !redir_valido && !chamada_valida && retorno_valido;
    w_redir     = redir_valido || chamada_valida || retorno_valido;
    w_alvo      = redir_alvo;
    if (w_pop) begin
      w_alvo = (r_qtd == '0) ? PC_INICIAL : r_pilha[w_topo_ant];
    end
  end

  assign erro_pilha = r_erro;
`else
  always_comb begin
    w_redir = redir_valido || chamada_valida;
    w_alvo  = redir_alvo;
  end

  logic w_unused;
  assign w_unused   = retorno_valido & (PROF_PILHA > 0);
  assign erro_pilha = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado   <= BUSCA;
      r_pc       <= PC_INICIAL;
      r_instr    <= '0;
      r_pc_instr <= '0;
      r_valida   <= 1'b0;
      r_parado   <= 1'b0;
`ifdef PILHA_RETORNO_EN
      r_pilha    <= '{default: '0};
      r_topo     <= '0;
      r_qtd      <= '0;
      r_erro     <= 1'b0;
`endif
    end else begin
      case (r_estado)
        BUSCA: begin
          if (w_redir) begin
            // squash the wrong-path byte arriving this edge; redirect beats stall
            r_pc     <= w_alvo;
            r_valida <= 1'b0;
`ifdef PILHA_RETORNO_EN
            if (w_push) begin
              r_pilha[r_topo] <= r_pc_instr + 1'b1;
              r_topo          <= w_topo_prox;
              if (r_qtd == c_LARGURA_QTD'(PROF_PILHA)) begin
                r_erro <= 1'b1;
              end else begin
                r_qtd <= r_qtd + 1'b1;
              end
            end else if (w_pop) begin
              if (r_qtd == '0) begin
                r_erro <= 1'b1;
              end else begin
                r_topo <= w_topo_ant;
                r_qtd  <= r_qtd - 1'b1;
              end
            end
`endif
          end else if (!stall) begin
            r_instr    <= instrucao_entrada;
            r_pc_instr <= r_pc;
            r_valida   <= 1'b1;
            if (instrucao_entrada == OPCODE_HALT) begin
              r_estado <= PARADO;
              r_parado <= 1'b1;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        PARADO: begin
          r_valida <= 1'b0;
        end
        default: begin
          r_estado <= BUSCA;
        end
      endcase
    end
  end

  assign endereco         = r_pc;
  assign instrucao_saida  = r_instr;
  assign pc_instrucao     = r_pc_instr;
  assign instrucao_valida = r_valida;
  assign parado           = r_parado;

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// ============================================================================
// tb_unidade_busca : scoreboard bench for unidade_busca with a byte memory model
// Revision 1.0
// ============================================================================
module tb_unidade_busca;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
  } esperado_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] endereco;
  logic [7:0] rdata;
  logic       stall = 1'b0;
  logic       redir_valido = 1'b0;
  logic [7:0] redir_alvo = 8'h00;
  logic       chamada_valida = 1'b0;
  logic       retorno_valido = 1'b0;
  logic [7:0] instrucao_saida;
  logic [7:0] pc_instrucao;
  logic       instrucao_valida;
  logic       parado;
  logic       erro_pilha;

  logic [7:0] mem [256];
  esperado_t  fila [$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic       r_segurado = 1'b0;

  unidade_busca dut (
    .clk               (clk),
    .reset             (reset),
    .endereco          (endereco),
    .instrucao_entrada (rdata),
    .stall             (stall),
    .redir_valido      (redir_valido),
    .redir_alvo        (redir_alvo),
    .chamada_valida    (chamada_valida),
    .retorno_valido    (retorno_valido),
    .instrucao_saida   (instrucao_saida),
    .pc_instrucao      (pc_instrucao),
    .instrucao_valida  (instrucao_valida),
    .parado            (parado),
    .erro_pilha        (erro_pilha)
  );

  always #5 clk = ~clk;

  // memory samples the address on negedge
  always @(negedge clk) rdata = mem[endereco];

  task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] exigido);
    n_total++;
    if (obtido !== exigido)
      $display("FAIL %s: got %0h expected %0h", nome, obtido, exigido);
    else
      n_pass++;
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  task automatic espera(input logic [7:0] instr, input logic [7:0] pc);
    esperado_t e;
    e.instr = instr;
    e.pc    = pc;
    fila.push_back(e);
  endtask

  // an edge with stall and no redirect leaves IF/ID untouched, so nothing new is presented
`ifdef PILHA_RETORNO_EN
  always @(posedge clk) r_segurado <= stall && !redir_valido && !chamada_valida && !retorno_valido;
`else
  always @(posedge clk) r_segurado <= stall && !redir_valido && !chamada_valida;
`endif

  always @(negedge clk) begin
    if (reset && instrucao_valida && !r_segurado) begin
      if (fila.size() == 0) begin
        chk("unexpected_output_pc", {24'h0, pc_instrucao}, 32'hFFFF_FFFF);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        chk("sb_instr", {24'h0, instrucao_saida}, {24'h0, e.instr});
        chk("sb_pc", {24'h0, pc_instrucao}, {24'h0, e.pc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_zerado(input string nome);
    chk({nome, "_end"}, {24'h0, endereco}, 32'h00);
    chk({nome, "_instr"}, {24'h0, instrucao_saida}, 32'h00);
    chk({nome, "_pc"}, {24'h0, pc_instrucao}, 32'h00);
    chk({nome, "_valid"}, {31'h0, instrucao_valida}, 32'h0);
    chk({nome, "_parado"}, {31'h0, parado}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'hFF] = 8'h5A;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    passo();
    passo();
    chk_zerado("reset");
    chk("reset_erro", {31'h0, erro_pilha}, 32'h0);

    // sequential fetch from reset
    espera(8'h11, 8'h00); espera(8'h22, 8'h01); espera(8'h33, 8'h02);
    espera(8'h44, 8'h03); espera(8'h04, 8'h04);
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      passo();
      chk("seq_end", {24'h0, endereco}, i);
    end

    // two-cycle stall at pc=5
    stall = 1'b1;
    passo();
    passo();
    chk("stall_end", {24'h0, endereco}, 32'h05);
    chk("stall_instr", {24'h0, instrucao_saida}, 32'h04);
    chk("stall_pc", {24'h0, pc_instrucao}, 32'h04);
    chk("stall_valid", {31'h0, instrucao_valida}, 32'h1);
    stall = 1'b0;
    espera(8'h05, 8'h05); espera(8'h06, 8'h06);
    passo();
    passo();
    chk("resume_end", {24'h0, endereco}, 32'h07);

    // redirect at pc=7
    redir_valido = 1'b1; redir_alvo = 8'h40;
    passo();
    redir_valido = 1'b0;
    chk("redir_valid", {31'h0, instrucao_valida}, 32'h0);
    chk("redir_end", {24'h0, endereco}, 32'h40);
    espera(8'h40, 8'h40);
    passo();
    chk("redir_next_end", {24'h0, endereco}, 32'h41);

    // call (plain redirect without the stack) to FD, wrap, then halt at 03
    chamada_valida = 1'b1; redir_alvo = 8'hFD;
    passo();
    chamada_valida = 1'b0;
    chk("call_valid", {31'h0, instrucao_valida}, 32'h0);
    chk("call_end", {24'h0, endereco}, 32'hFD);
    mem[3] = 8'hFF;
    espera(8'hFD, 8'hFD); espera(8'hFE, 8'hFE); espera(8'h5A, 8'hFF);
    espera(8'h11, 8'h00); espera(8'h22, 8'h01); espera(8'h33, 8'h02);
    espera(8'hFF, 8'h03);
    for (int i = 1; i <= 7; i++) begin
      passo();
      if (i == 3) chk("wrap_end", {24'h0, endereco}, 32'h00);
      if (i == 6) chk("prehalt_parado", {31'h0, parado}, 32'h0);
    end
    chk("halt_parado", {31'h0, parado}, 32'h1);
    chk("halt_valid", {31'h0, instrucao_valida}, 32'h1);
    chk("halt_instr", {24'h0, instrucao_saida}, 32'hFF);
    chk("halt_end", {24'h0, endereco}, 32'h03);
    redir_valido = 1'b1; redir_alvo = 8'h20;
    passo();
    chk("parado_valid", {31'h0, instrucao_valida}, 32'h0);
    chk("parado_end", {24'h0, endereco}, 32'h03);
    passo();
    redir_valido = 1'b0;
    chk("parado_hold_end", {24'h0, endereco}, 32'h03);
    chk("parado_hold", {31'h0, parado}, 32'h1);

    // asynchronous reset while halted
    reset = 1'b0;
    #1;
    chk_zerado("rst_parado");
    passo();
    reset = 1'b1;

    // redirect coinciding with a halt byte: redirect wins
    espera(8'h11, 8'h00); espera(8'h22, 8'h01); espera(8'h33, 8'h02);
    passo(); passo(); passo();
    chk("rh_pre_end", {24'h0, endereco}, 32'h03);
    redir_valido = 1'b1; redir_alvo = 8'h10;
    passo();
    redir_valido = 1'b0;
    chk("rh_parado", {31'h0, parado}, 32'h0);
    chk("rh_valid", {31'h0, instrucao_valida}, 32'h0);
    chk("rh_end", {24'h0, endereco}, 32'h10);

    // asynchronous reset under stall
    espera(8'h10, 8'h10);
    passo();
    stall = 1'b1;
    passo();
    chk("stall2_end", {24'h0, endereco}, 32'h11);
    reset = 1'b0;
    #1;
    chk_zerado("rst_stall");
    stall = 1'b0;
    passo();
    reset = 1'b1;

`ifdef PILHA_RETORNO_EN
    // call from pc 0x10 to 0x80, then return to 0x11
    redir_valido = 1'b1; redir_alvo = 8'h10;
    passo();
    redir_valido = 1'b0;
    espera(8'h10, 8'h10);
    passo();
    chamada_valida = 1'b1; redir_alvo = 8'h80;
    passo();
    chamada_valida = 1'b0;
    chk("pcall_end", {24'h0, endereco}, 32'h80);
    espera(8'h80, 8'h80);
    passo();
    retorno_valido = 1'b1;
    passo();
    retorno_valido = 1'b0;
    chk("pret_end", {24'h0, endereco}, 32'h11);
    chk("pret_valid", {31'h0, instrucao_valida}, 32'h0);
    chk("pret_erro", {31'h0, erro_pilha}, 32'h0);

    // five nested calls overflow a four-deep stack (pushed value 0x81)
    chamada_valida = 1'b1; redir_alvo = 8'h90;
    for (int i = 1; i <= 5; i++) begin
      passo();
      if (i == 4) chk("push4_erro", {31'h0, erro_pilha}, 32'h0);
    end
    chamada_valida = 1'b0;
    chk("push5_erro", {31'h0, erro_pilha}, 32'h1);
    retorno_valido = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      passo();
      chk("pop_end", {24'h0, endereco}, 32'h81);
    end
    passo();
    retorno_valido = 1'b0;
    chk("pop_vazio_end", {24'h0, endereco}, 32'h00);
    chk("pop_vazio_erro", {31'h0, erro_pilha}, 32'h1);
`else
    chk("erro_tied", {31'h0, erro_pilha}, 32'h0);
`endif

    stall = 1'b1;
    passo();
    passo();
    chk("fila_vazia", fila.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
